// File: rtl/carregador_inst_if.sv
// carregador_inst_if: byte-stream handshake plus instruction-memory write port of the loader.
interface carregador_inst_if;
  logic [7:0]  byte_dado;
  logic        byte_valido;
  logic        byte_pronto;
  logic [31:0] instrucao;
  logic        OpMemIns;
  logic [31:0] endLeitura;
  modport master (input byte_dado, byte_valido, output byte_pronto, instrucao, OpMemIns, endLeitura);
  modport slave  (output byte_dado, byte_valido, input byte_pronto, instrucao, OpMemIns, endLeitura);
endinterface

// File: rtl/carregador_inst.sv
// carregador_inst: assembles a little-endian byte stream into 32-bit words written at sequential addresses.
// Define CARREGADOR_CHECKSUM_EN to append a 4-byte sum check (erro) after the last word.
module carregador_inst #(
  parameter int ADDR_W = 14
) (
  input  logic                    clock_auto,
  input  logic                    reset_n,
  input  logic                    iniciar,
  input  logic [31:0]             end_base,
  input  logic [15:0]             num_palavras,
  output logic                    ocupado,
  output logic                    concluido,
  output logic                    erro,
  carregador_inst_if.master       bus
);
`ifdef CARREGADOR_CHECKSUM_EN
  typedef enum logic [2:0] {OCIOSO, RECEBE, ESCREVE, CHECA, FIM} estado_t;
  logic [31:0] soma;
`else
  typedef enum logic [2:0] {OCIOSO, RECEBE, ESCREVE, FIM} estado_t;
  assign erro = 1'b0;
`endif
  estado_t           estado;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       restantes;
  logic [1:0]        idx;
  logic [23:0]       parcial;
  logic [31:0]       instrucao_r;
  logic              op_r, pronto_r;
  logic              aceita, unused_ok;
  assign aceita         = bus.byte_valido & pronto_r;
  assign bus.byte_pronto = pronto_r;
  assign bus.instrucao  = instrucao_r;
  assign bus.OpMemIns   = op_r;
  assign bus.endLeitura = 32'(addr);
  assign unused_ok      = &{1'b0, end_base[31:ADDR_W]};
  // Bytes shift in from the top, so after three accepts parcial holds {b2,b1,b0}.
  always_ff @(posedge clock_auto or negedge reset_n) begin
    if (!reset_n) begin
      estado      <= OCIOSO;
      addr        <= '0;
      restantes   <= '0;
      idx         <= '0;
      parcial     <= '0;
      instrucao_r <= '0;
      op_r        <= 1'b0;
      pronto_r    <= 1'b0;
      ocupado     <= 1'b0;
      concluido   <= 1'b0;
`ifdef CARREGADOR_CHECKSUM_EN
      soma        <= '0;
      erro        <= 1'b0;
`endif
    end else begin
      case (estado)
        OCIOSO: if (iniciar) begin
          addr      <= end_base[ADDR_W-1:0];
          restantes <= num_palavras;
          idx       <= '0;
          parcial   <= '0;
`ifdef CARREGADOR_CHECKSUM_EN
          soma      <= '0;
          erro      <= 1'b0;
`endif
          if (num_palavras == 16'd0) begin
            estado    <= FIM;
            concluido <= 1'b1;
          end else begin
            estado   <= RECEBE;
            pronto_r <= 1'b1;
            ocupado  <= 1'b1;
          end
        end
        RECEBE: if (aceita) begin
          idx     <= idx + 2'd1;
          parcial <= {bus.byte_dado, parcial[23:8]};
          if (idx == 2'd3) begin
            instrucao_r <= {bus.byte_dado, parcial};
            op_r        <= 1'b1;
            pronto_r    <= 1'b0;
            estado      <= ESCREVE;
          end
        end
        ESCREVE: begin
          op_r      <= 1'b0;
          addr      <= addr + ADDR_W'(1);
          restantes <= restantes - 16'd1;
`ifdef CARREGADOR_CHECKSUM_EN
          soma      <= soma + instrucao_r;
`endif
          if (restantes != 16'd1) begin
            estado   <= RECEBE;
            pronto_r <= 1'b1;
          end else begin
`ifdef CARREGADOR_CHECKSUM_EN
            estado   <= CHECA;
            pronto_r <= 1'b1;
`else
            estado    <= FIM;
            ocupado   <= 1'b0;
            concluido <= 1'b1;
`endif
          end
        end
`ifdef CARREGADOR_CHECKSUM_EN
        CHECA: if (aceita) begin
          idx     <= idx + 2'd1;
          parcial <= {bus.byte_dado, parcial[23:8]};
          if (idx == 2'd3) begin
            erro      <= soma != {bus.byte_dado, parcial};
            pronto_r  <= 1'b0;
            ocupado   <= 1'b0;
            concluido <= 1'b1;
            estado    <= FIM;
          end
        end
`endif
        FIM: begin
          concluido <= 1'b0;
          estado    <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end
endmodule

// File: doc/carregador_inst.md
# carregador_inst

Instruction loader: the writer side of the instruction-memory write port. It accepts a stream of bytes over a valid/ready handshake and assembles them little-endian into 32-bit instructions. It writes each word into the instruction memory at sequential word addresses from a programmable base, using the memory's `instrucao`/`OpMemIns`/`endLeitura` write port. It sits between the host/boot byte source and the instruction memory and runs before the processor is released.

## Interface
Parameters:
- `ADDR_W`, default 14: memory word-address width. Memory depth is 2**ADDR_W words.

Ports:
- `clock_auto`, in, 1: system clock; all state updates on the rising edge.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `iniciar`, in, 1: start pulse; sampled only in OCIOSO.
- `end_base`, in, 32: first word address; captured on accepted `iniciar`.
- `num_palavras`, in, 16: number of words to load; captured on accepted `iniciar`.
- `byte_dado`, in, 8: stream byte.
- `byte_valido`, in, 1: `byte_dado` is valid.
- `byte_pronto`, out, 1: loader can accept a byte.
- `instrucao`, out, 32: assembled word to the memory.
- `OpMemIns`, out, 1: memory write enable.
- `endLeitura`, out, 32: memory write address. Low `ADDR_W` bits carry the address; upper bits are always 0.
- `ocupado`, out, 1: load in progress.
- `concluido`, out, 1: one-cycle done pulse.
- `erro`, out, 1: checksum mismatch. Constant 0 without `CARREGADOR_CHECKSUM_EN`.

## Operation
- FSM states: OCIOSO, RECEBE, ESCREVE, CHECA (only with checksum), FIM.
- OCIOSO:
  - `iniciar`=1 latches `end_base[ADDR_W-1:0]` into the address counter and `num_palavras` into the remaining-word counter.
  - It clears the byte index, the accumulator and `erro`.
  - Next state is RECEBE, or FIM if `num_palavras`=0.
- RECEBE:
  - `byte_pronto`=1. A byte is accepted on a rising edge with `byte_valido`=1 and `byte_pronto`=1.
  - Byte index i (0..3) fills bits [8i+7:8i].
  - On acceptance of byte 3, the word is registered into `instrucao` and the FSM goes to ESCREVE.
- ESCREVE (exactly one cycle):
  - `OpMemIns`=1, `byte_pronto`=0.
  - `instrucao` and `endLeitura` are stable for the whole cycle.
  - On exit: address counter increments modulo 2**ADDR_W (0x3FFF wraps to 0x0000), remaining-word counter decrements.
  - Next state is RECEBE if words remain, otherwise CHECA (checksum build) or FIM.
- FIM (one cycle): `concluido`=1, `ocupado`=0. Next state is OCIOSO.
- `ocupado`=1 in RECEBE, ESCREVE and CHECA.
- `iniciar` outside OCIOSO is ignored.
- `byte_valido` with `byte_pronto`=0 is not consumed. The source must hold the byte.
- Reset asserted mid-operation:
  - Immediate return to OCIOSO.
  - Any partial word is discarded.
  - No write is issued.
- Reset value of every output: 0. This covers `byte_pronto`, `instrucao`, `OpMemIns`, `endLeitura`, `ocupado`, `concluido` and `erro`.

## Timing
- `iniciar` sampled at edge 0:
  - `ocupado`=1 and `byte_pronto`=1 from cycle 1.
  - If `num_palavras`=0, `concluido`=1 in cycle 1 instead.
- Fourth byte accepted at edge k:
  - `OpMemIns`=1 during cycle k→k+1.
  - The memory captures the word at edge k+1.
  - `byte_pronto`=1 again from cycle k+1.
- Minimum 5 cycles per word: 4 accepts plus 1 write.
- `concluido` is asserted in the cycle after the final ESCREVE (or after the final CHECA byte).
- `OpMemIns` is never high for more than one consecutive cycle.

## Configuration
- `CARREGADOR_CHECKSUM_EN` defined:
  - A 32-bit accumulator sums every written word, modulo 2**32.
  - After the last word, CHECA accepts 4 more bytes, little-endian, as the expected sum. No memory write is issued for them.
  - On the 4th CHECA byte: `erro` := (sum ≠ received). `erro` is held until the next accepted `iniciar` or reset.
  - `concluido` pulses regardless of `erro`.
- Not defined:
  - No CHECA state and no accumulator.
  - `erro` is tied to 0.
  - The stream is exactly 4×`num_palavras` bytes.

## Test plan
- Reset: hold `reset_n`=0 with arbitrary inputs → every output 0. Release, no `iniciar` → stays OCIOSO, `OpMemIns` never 1.
- Basic load: `end_base`=0x10, `num_palavras`=2, bytes 78 56 34 12 EF BE AD DE with `byte_valido` continuous → writes 0x12345678@0x10 then 0xDEADBEEF@0x11. `concluido` pulses once. Memory readback matches.
- Stalls: same stream with `byte_valido` toggling 1/0 and random gaps → identical two writes, no duplicated or dropped byte, `OpMemIns` pulses exactly twice.
- Zero count and wrap:
  - `num_palavras`=0 → `concluido`=1 one cycle after `iniciar`, no write.
  - `end_base`=0x3FFF, `num_palavras`=2 → writes at 0x3FFF then 0x0000.
- Reset mid-word: assert `reset_n`=0 after 2 of 4 bytes → outputs 0, no write. A fresh load afterwards of 1 word 0xCAFEF00D@0 succeeds.
- Checksum (`CARREGADOR_CHECKSUM_EN`): words 0x00000001 and 0x00000002 followed by sum bytes 03 00 00 00 → `erro`=0. Same words with sum bytes 04 00 00 00 → `erro`=1 and `concluido` pulses.
